// File: rtl/pipe_seg_fifo_pkg.sv
// Shared pipeline-segment definitions: reset PC, bubble instruction and the
// default {pc, inst} payload carried between front-end stages.
package pipe_seg_fifo_pkg;

    localparam logic [31:0] PC_RST = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } seg_payload_t;

    localparam seg_payload_t SEG_BUBBLE = '{pc: PC_RST, inst: NOP};

    function automatic seg_payload_t seg_pack(input logic [31:0] pc, input logic [31:0] inst);
        seg_payload_t p;
        p.pc   = pc;
        p.inst = inst;
        return p;
    endfunction

endpackage

// File: rtl/pipe_seg_fifo.sv
// DEPTH-entry first-word-fall-through buffer between two pipeline stages,
// with valid/ready on both sides, registered ready and a synchronous flush.
module pipe_seg_fifo
    import pipe_seg_fifo_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter int unsigned       DEPTH      = 2,
    parameter logic [DATA_W-1:0] EMPTY_DATA = DATA_W'(SEG_BUBBLE),
    parameter int unsigned       CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pipe_seg_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Status is derived from the registered count only, so in_ready has no
    // combinational dependence on out_ready.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && !full && !flush_i;
        pop       = !empty && out_ready && !flush_i;
        out_data  = empty ? EMPTY_DATA : mem[rd_ptr];
        count     = count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage carries no reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_seg_fifo.sv
// Scoreboard bench for pipe_seg_fifo: directed stage-buffer scenarios on a
// DEPTH=2 instance and a randomised run on a DEPTH=4 instance.
module tb_pipe_seg_fifo;

    localparam int          D2    = 2;
    localparam int          D4    = 4;
    localparam logic [63:0] EMPTY = 64'h8000_0000_0000_0013;

    logic        clk = 1'b0;
    logic        rst;

    logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [63:0] in_data2, out_data2;
    logic [1:0]  count2;

    logic        flush4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [63:0] in_data4, out_data4;
    logic [2:0]  count4;

    int tests = 0;
    int fails = 0;

    logic [63:0] q2[$];
    logic [63:0] q4[$];

    always #5 clk = ~clk;

    pipe_seg_fifo #(.DATA_W(64), .DEPTH(D2)) u2 (
        .clk(clk), .rst(rst), .flush_i(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .count(count2)
    );

    pipe_seg_fifo #(.DATA_W(64), .DEPTH(D4)) u4 (
        .clk(clk), .rst(rst), .flush_i(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .count(count4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model for the DEPTH=2 instance: an ordered queue of accepted payloads.
    always @(negedge clk) begin : mon2
        bit          do_pop, do_push;
        logic [63:0] head;
        if (!rst) q2.delete();
        chk("u2_out_valid", 64'(out_valid2), 64'(q2.size() != 0));
        chk("u2_count",     64'(count2),     64'(q2.size()));
        chk("u2_in_ready",  64'(in_ready2),  64'(q2.size() != D2));
        chk("u2_out_data",  out_data2,       (q2.size() != 0) ? q2[0] : EMPTY);
        if (rst) begin
            if (flush2) begin
                q2.delete();
            end else begin
                do_pop  = (q2.size() != 0) && out_ready2;
                do_push = in_valid2 && (q2.size() != D2);
                if (do_pop) begin
                    head = q2.pop_front();
                    chk("u2_pop_order", out_data2, head);
                end
                if (do_push) q2.push_back(in_data2);
            end
        end
    end

    always @(negedge clk) begin : mon4
        bit          do_pop, do_push;
        logic [63:0] head;
        if (!rst) q4.delete();
        chk("u4_out_valid", 64'(out_valid4), 64'(q4.size() != 0));
        chk("u4_count",     64'(count4),     64'(q4.size()));
        chk("u4_in_ready",  64'(in_ready4),  64'(q4.size() != D4));
        chk("u4_out_data",  out_data4,       (q4.size() != 0) ? q4[0] : EMPTY);
        if (rst) begin
            if (flush4) begin
                q4.delete();
            end else begin
                do_pop  = (q4.size() != 0) && out_ready4;
                do_push = in_valid4 && (q4.size() != D4);
                if (do_pop) begin
                    head = q4.pop_front();
                    chk("u4_pop_order", out_data4, head);
                end
                if (do_push) q4.push_back(in_data4);
            end
        end
    end

    function automatic logic [63:0] pay(input int unsigned i);
        logic [31:0] pc;
        logic [31:0] inst;
        pc   = 32'h8000_0000 + 32'(4 * i);
        inst = 32'h0000_0413 + 32'(i << 7);
        return {pc, inst};
    endfunction

    // Offer one payload and hold it until the buffer takes it.
    task automatic send2(input logic [63:0] d);
        in_valid2 = 1'b1;
        in_data2  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready2) begin
                @(posedge clk);
                #1;
                in_valid2 = 1'b0;
                return;
            end
        end
        fails++;
        $display("FAIL send2_timeout: in_ready stayed %b, required 1", in_ready2);
        in_valid2 = 1'b0;
    endtask

    task automatic directed2();
        // First push after reset, visible one cycle later.
        out_ready2 = 1'b0;
        send2(pay(0));
        chk("first_count",     64'(count2),     64'd1);
        chk("first_out_valid", 64'(out_valid2), 64'd1);
        chk("first_out_data",  out_data2,       64'h8000_0000_0000_0413);
        out_ready2 = 1'b1;
        @(posedge clk); #1;

        // Back-to-back streaming: occupancy stays at one, no bubbles.
        for (int unsigned i = 0; i < 8; i++) begin
            send2(pay(i));
            chk("stream_count", 64'(count2), 64'd1);
        end
        repeat (2) @(posedge clk);
        #1;

        // Downstream stall: two fill the buffer, the third is held.
        out_ready2 = 1'b0;
        send2(pay(0));
        send2(pay(1));
        chk("stall_count",    64'(count2),    64'd2);
        chk("stall_in_ready", 64'(in_ready2), 64'd0);
        fork
            send2(pay(2));
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready2 = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("drain_count", 64'(count2), 64'd0);

        // Flush with a simultaneous push and pop offered.
        out_ready2 = 1'b0;
        send2(pay(20));
        send2(pay(21));
        chk("preflush_count", 64'(count2), 64'd2);
        flush2     = 1'b1;
        in_valid2  = 1'b1;
        in_data2   = 64'hDEAD_BEEF_DEAD_BEEF;
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        flush2    = 1'b0;
        in_valid2 = 1'b0;
        chk("flush_count",     64'(count2),     64'd0);
        chk("flush_out_valid", 64'(out_valid2), 64'd0);
        chk("flush_out_data",  out_data2,       EMPTY);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic random4();
        bit acc;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            acc = in_valid4 && in_ready4 && !flush4;
            @(posedge clk); #1;
            // Upstream keeps an unaccepted payload stable.
            if (!in_valid4 || acc || flush4) begin
                in_valid4 = ($urandom_range(0, 3) != 0);
                in_data4  = {$urandom, $urandom};
            end
            if ((c % 200) < 100) out_ready4 = ($urandom_range(0, 2) == 0);
            else                 out_ready4 = ($urandom_range(0, 2) != 0);
            flush4 = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk); #1;
        flush4    = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic async_reset4();
        flush4     = 1'b1;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        @(posedge clk); #1;
        flush4    = 1'b0;
        in_valid4 = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            in_data4 = pay(40 + i);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        chk("async_pre_count", 64'(count4), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid4), 64'd0);
        chk("async_count",     64'(count4),     64'd0);
        chk("async_in_ready",  64'(in_ready4),  64'd1);
        chk("async_out_data",  out_data4,       EMPTY);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        flush2     = 1'b0;
        in_valid2  = 1'b1;
        in_data2   = pay(0);
        out_ready2 = 1'b0;
        flush4     = 1'b0;
        in_valid4  = 1'b1;
        in_data4   = pay(1);
        out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid2), 64'd0);
        chk("rst_out_data",  out_data2,       EMPTY);
        chk("rst_count",     64'(count2),     64'd0);
        chk("rst_in_ready",  64'(in_ready2),  64'd1);
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;

        fork
            directed2();
            random4();
        join
        async_reset4();
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pipe_seg_fifo.md
Name: pipe_seg_fifo

Overview:
Parametrised pipeline segment buffer that replaces fixed single-entry stage registers such as IFU→IDU.
It is a DEPTH-entry first-word-fall-through FIFO with valid/ready handshakes on both sides, so an upstream stage can keep issuing while the downstream stage stalls.
A synchronous flush discards all in-flight entries on a branch redirect.
When empty, the output presents a bubble payload (NOP/PC_RST) with out_valid low, which is equivalent to commit=false.

Parameters:
DATA_W, 64, payload width (default is {pc[31:0], inst[31:0]}).
DEPTH, 2, number of entries; power of two, ≥2.
EMPTY_DATA, {PC_RST, NOP}, value driven on out_data while empty.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (rst=0 resets)
flush_i  in  1  synchronous flush; discards all entries
in_valid  in  1  upstream presents in_data
in_ready  out  1  buffer can accept; equals !full
in_data  in  DATA_W  upstream payload
out_valid  out  1  head entry valid (commit flag for the next stage)
out_ready  in  1  downstream consumes head this cycle
out_data  out  DATA_W  head payload, or EMPTY_DATA when empty
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=0, asynchronous assert; deassertion sampled on clk):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_data=EMPTY_DATA, in_ready=1.
  - Storage array is not reset.
- Handshakes:
  - push = in_valid & in_ready & !flush_i.
  - pop = out_valid & out_ready & !flush_i.
- in_ready = (count != DEPTH). It is registered-derived only and never depends on out_ready, so there is no combinational ready path. When full, a same-cycle pop does not allow a push.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when count != 0, else EMPTY_DATA. This is combinational from registered state.
- Latency: a payload pushed in cycle N appears on out_data/out_valid in cycle N+1. There is no bypass.
- Pointers:
  - Width $clog2(DEPTH); each wraps naturally from DEPTH-1 to 0.
  - push: mem[wr_ptr]<=in_data, wr_ptr++.
  - pop: rd_ptr++.
- count update:
  - push only: +1.
  - pop only: -1.
  - push&pop: unchanged.
  - Neither: unchanged.
  - count never exceeds DEPTH and never underflows.
- Flush (flush_i=1 at a clock edge): wr_ptr<=0, rd_ptr<=0, count<=0.
  - Flush overrides push and pop in the same cycle; the in_data offered that cycle is dropped.
  - Next cycle: out_valid=0, out_data=EMPTY_DATA.
  - Flush has no stall-gating; the producer of flush_i is responsible for gating it with the downstream stall.
- Pop while empty is impossible, because out_valid=0.
- Push while full is impossible, because in_ready=0. Upstream must hold in_data stable while in_valid & !in_ready.
- Reset mid-operation: all entries are lost immediately and outputs go to their reset values asynchronously.
- Stall mapping: a downstream stall is out_ready=0. An upstream stall arises naturally from in_ready=0 once the FIFO is full.
- DEPTH=2 provides full throughput with registered ready (skid behaviour).

Decomposition:
- Shared package (DEFINES): PC_RST, NOP, true/false constants, and the seg_payload_t struct {pc[31:0], inst[31:0]}.
- EMPTY_DATA defaults to the packed {PC_RST, NOP}.
- No sub-module is required. Pointer/count logic stays inline.
- Later stage pairs (IDU→EXU, etc.) instantiate this block with their own DATA_W and EMPTY_DATA.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → out_valid=0, out_data=EMPTY_DATA, count=0, in_ready=1. After release, the first push of {0x80000000, 0x00000413} is visible on the next cycle with count=1.
- Back-to-back streaming: DEPTH=2, out_ready=1, push pc=0x80000000,+4,+8… each cycle → out_data follows one cycle later, count stays at 1, no bubbles.
- Downstream stall: out_ready=0, push 3 payloads → count=2, in_ready=0 after the 2nd push, the 3rd is held. Raise out_ready → entries drain in order 0x80000000, 0x80000004, 0x80000008.
- Flush with simultaneous push/pop: count=2, flush_i=1 with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_data=EMPTY_DATA, and the flushed-cycle payload never appears.
- Wrap-around: DEPTH=4, random in_valid/out_ready over 1000 cycles against a scoreboard queue → order preserved, count matches the model, pointers wrap cleanly.
- Async reset mid-stream: assert rst=0 between clock edges while count=3 → out_valid drops without waiting for a clock edge, and count=0.
